pfd_cpump_core: RTL and testbench

- Digital real-number-model core of the PLL phase-frequency detector plus charge-pump integrator.
- Oversamples the reference and feedback clocks with a fast system clock and produces UP/DOWN pulses.
- Integrates those pulses into a saturating control-voltage code and flags lock.
- Sits between the clock sources and the loop-filter/VCO model.

---
 rtl/pfd_cpump_core.sv | 149 ++++++++++++++
 tb/tb_pfd_cpump_core.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pfd_cpump_core.sv
`default_nettype none
// ============================================================================
// Module : pfd_cpump_core
// Oversampled phase-frequency detector + saturating charge-pump integrator
// with lock detection. Optional leakage enabled by macro CPUMP_LEAK_EN.
// Rev    : 1.0
// ============================================================================
module pfd_cpump_core #(
  parameter int W           = 12,
  parameter int IC_CODE     = 2048,
  parameter int VMAX        = 4095,
  parameter int I_UP        = 8,
  parameter int I_DN        = 8,
  parameter int RST_DLY     = 1,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_CNT    = 16,
  parameter int LEAK_PERIOD = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         d,
  input  logic         refclk,
  input  logic         finalclk,
  output logic         up,
  output logic         down,
  output logic [W-1:0] vctrl,
  output logic         lock
);

  localparam int C_OVW = $clog2(RST_DLY + 1);
  localparam int C_GW  = $clog2(LOCK_CNT + 1);
  localparam logic signed [W+1:0] C_UP   = (W+2)'(I_UP);
  localparam logic signed [W+1:0] C_DN   = (W+2)'(I_DN);
  localparam logic signed [W+1:0] C_VMAX = (W+2)'(VMAX);
  localparam logic signed [W+1:0] C_ZERO = '0;
  localparam logic [C_OVW-1:0]    C_OVL  = C_OVW'(RST_DLY - 1);
  localparam logic [C_GW-1:0]     C_GMAX = C_GW'(LOCK_CNT);
  localparam logic [7:0]          C_TOL  = 8'(LOCK_TOL);

  if (RST_DLY < 1 || LOCK_CNT < 1 || LEAK_PERIOD < 2) begin : g_param_chk
    $error("pfd_cpump_core: illegal parameter value");
  end

  logic              r_ref_s1, r_ref_s2, r_ref_prev;
  logic              r_fb_s1, r_fb_s2, r_fb_prev;
  logic [C_OVW-1:0]  r_ov_cnt;
  logic [7:0]        r_width;
  logic [C_GW-1:0]   r_good;
  logic              w_ref_edge, w_fb_edge, w_clr, w_leak_tick;
  logic [C_GW-1:0]   w_good_nxt;
  logic signed [W+1:0] w_sum;
  logic [W-1:0]      w_pump, w_vnext;

  // Two-flop synchronizers plus edge history keep running regardless of d.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_s1   <= 1'b0;
      r_ref_s2   <= 1'b0;
      r_ref_prev <= 1'b0;
      r_fb_s1    <= 1'b0;
      r_fb_s2    <= 1'b0;
      r_fb_prev  <= 1'b0;
    end else begin
      r_ref_s1   <= refclk;
      r_ref_s2   <= r_ref_s1;
      r_ref_prev <= r_ref_s2;
      r_fb_s1    <= finalclk;
      r_fb_s2    <= r_fb_s1;
      r_fb_prev  <= r_fb_s2;
    end
  end

`ifdef CPUMP_LEAK_EN
  localparam int C_LW = $clog2(LEAK_PERIOD);
  logic [C_LW-1:0] r_leak_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_leak_cnt <= '0;
    end else if (w_leak_tick) begin
      r_leak_cnt <= '0;
    end else begin
      r_leak_cnt <= r_leak_cnt + C_LW'(1);
    end
  end

  assign w_leak_tick = (r_leak_cnt == C_LW'(LEAK_PERIOD - 1));
`else
  assign w_leak_tick = 1'b0;
`endif

  always_comb begin
    w_ref_edge = r_ref_s2 & ~r_ref_prev;
    w_fb_edge  = r_fb_s2 & ~r_fb_prev;
    w_clr      = up & down & (r_ov_cnt == C_OVL);

    if (r_width <= C_TOL) begin
      w_good_nxt = (r_good == C_GMAX) ? r_good : r_good + C_GW'(1);
    end else begin
      w_good_nxt = '0;
    end

    w_sum = $signed({2'b00, vctrl}) + (up ? C_UP : C_ZERO) - (down ? C_DN : C_ZERO);
    if (w_sum < C_ZERO) begin
      w_pump = '0;
    end else if (w_sum > C_VMAX) begin
      w_pump = W'(VMAX);
    end else begin
      w_pump = w_sum[W-1:0];
    end

    // Leak is applied after saturation so it can pull down from VMAX but never wrap below 0.
    w_vnext = (w_leak_tick && (w_pump != '0)) ? w_pump - W'(1) : w_pump;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up       <= 1'b0;
      down     <= 1'b0;
      vctrl    <= W'(IC_CODE);
      lock     <= 1'b0;
      r_ov_cnt <= '0;
      r_width  <= '0;
      r_good   <= '0;
    end else if (!d) begin
      up       <= 1'b0;
      down     <= 1'b0;
      lock     <= 1'b0;
      r_ov_cnt <= '0;
      r_width  <= '0;
      r_good   <= '0;
    end else begin
      // An edge arriving in the clearing cycle re-arms its output.
      up       <= (up & ~w_clr) | w_ref_edge;
      down     <= (down & ~w_clr) | w_fb_edge;
      r_ov_cnt <= (up & down & ~w_clr) ? r_ov_cnt + C_OVW'(1) : '0;
      vctrl    <= w_vnext;
      if (w_ref_edge) begin
        r_width <= '0;
        r_good  <= w_good_nxt;
        lock    <= (w_good_nxt == C_GMAX);
      end else if ((up ^ down) && (r_width != 8'hFF)) begin
        r_width <= r_width + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pfd_cpump_core.sv
`default_nettype none
// ============================================================================
// Module : tb_pfd_cpump_core
// Directed bench for pfd_cpump_core with a cycle-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_pfd_cpump_core;
  localparam int W = 12;
`ifdef CPUMP_LEAK_EN
  localparam bit LEAK = 1'b1;
`else
  localparam bit LEAK = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, d = 1'b1, refclk = 1'b0, finalclk = 1'b0;
  logic up, down, lock;
  logic [W-1:0] vctrl;

  int n_cmp = 0, n_err = 0;
  bit chk_on = 1'b0;
  int tph = 0, ref_off = 0, fb_off = 0;
  bit ref_on = 1'b0, fb_on = 1'b0;
  int cu, cd;

  // model state
  bit rq[$], fq[$];
  int mv = 2048, mu = 0, md = 0, mw = 0, mg = 0, mb = 0, ml = 0, cyc = 0;

  pfd_cpump_core #(
    .W(W), .IC_CODE(2048), .VMAX(4095), .I_UP(8), .I_DN(8), .RST_DLY(1),
    .LOCK_TOL(2), .LOCK_CNT(16), .LEAK_PERIOD(256)
  ) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .refclk(refclk), .finalclk(finalclk),
    .up(up), .down(down), .vctrl(vctrl), .lock(lock)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    rq = '{1'b0, 1'b0, 1'b0, 1'b0};
    fq = '{1'b0, 1'b0, 1'b0, 1'b0};
    mv = 2048; mu = 0; md = 0; mw = 0; mg = 0; mb = 0; ml = 0; cyc = 0;
  endtask

  // Model: edge seen at input sample n-2 (with n-3 low) sets the output at edge n.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_reset();
    end else begin
      bit rev, fev, clr;
      int nv;
      rq.push_front(refclk); void'(rq.pop_back());
      fq.push_front(finalclk); void'(fq.pop_back());
      rev = rq[2] && !rq[3];
      fev = fq[2] && !fq[3];
      nv = mv;
      if (d) begin
        nv = mv + (mu * 8) - (md * 8);
        if (nv < 0) nv = 0;
        if (nv > 4095) nv = 4095;
        if (LEAK && (cyc % 256 == 255) && nv > 0) nv = nv - 1;
      end
      cyc++;
      mv = nv;
      if (!d) begin
        mu = 0; md = 0; mw = 0; mg = 0; mb = 0; ml = 0;
      end else begin
        clr = 1'b0;
        if (mu == 1 && md == 1) begin
          mb++;
          if (mb >= 1) begin clr = 1'b1; mb = 0; end
        end else begin
          mb = 0;
        end
        if (rev) begin
          mg = (mw <= 2) ? ((mg < 16) ? mg + 1 : 16) : 0;
          mw = 0;
          ml = (mg == 16) ? 1 : 0;
        end else if (mu != md && mw < 255) begin
          mw++;
        end
        mu = ((mu == 1 && !clr) || rev) ? 1 : 0;
        md = ((md == 1 && !clr) || fev) ? 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      if (!rst_n) begin
        check("rst_up", up, 0);
        check("rst_down", down, 0);
        check("rst_vctrl", vctrl, 2048);
        check("rst_lock", lock, 0);
      end else begin
        check("up", up, mu);
        check("down", down, md);
        check("vctrl", vctrl, mv);
        check("lock", lock, ml);
      end
    end
  end

  function automatic bit wave(input int t, input int off);
    return ((t + 20 - off) % 20) < 10;
  endfunction

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      refclk   = ref_on ? wave(tph, ref_off) : 1'b0;
      finalclk = fb_on ? wave(tph, fb_off) : 1'b0;
      tph++;
    end
  endtask

  task automatic run_count(input int n, output int nu, output int nd);
    nu = 0; nd = 0;
    for (int i = 0; i < n; i++) begin
      run(1);
      nu += int'(up);
      nd += int'(down);
    end
  endtask

  task automatic start(input bit ron, input bit fon, input int roff, input int foff);
    @(posedge clk); #2;
    rst_n = 1'b0; refclk = 1'b0; finalclk = 1'b0; d = 1'b1;
    ref_on = ron; fb_on = fon; ref_off = roff; fb_off = foff; tph = 0;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    // reset with refclk toggling
    @(posedge clk); #2;
    chk_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      refclk = ~refclk;
    end
    check("hold_up", up, 0);
    check("hold_down", down, 0);
    check("hold_lock", lock, 0);
    check("hold_vctrl", vctrl, 2048);
    refclk = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    run(30);
    check("idle_vctrl", vctrl, 2048);

    // leak (or its absence) with no edges
    start(1'b0, 1'b0, 0, 0);
    run(256);
    check("leak256", vctrl, LEAK ? 2047 : 2048);
    run(256);
    check("leak512", vctrl, LEAK ? 2046 : 2048);

    // in phase: one-cycle overlap pulses, lock on 16th good edge
    start(1'b1, 1'b1, 0, 0);
    run_count(20, cu, cd);
    check("inph_upw", cu, 1);
    check("inph_dnw", cd, 1);
    run(280);
    check("inph_lock15", lock, 0);
    run(20);
    check("inph_lock16", lock, 1);
    check("inph_vctrl", vctrl, LEAK ? 2047 : 2048);

    // ref leads by 5: +40 per period, saturate at top
    start(1'b1, 1'b1, 0, 5);
    run_count(15, cu, cd);
    check("lead_upw", cu, 6);
    check("lead_dnw", cd, 1);
    check("lead_vctrl1", vctrl, 2088);
    run(1200);
    check("lead_ceiling", vctrl, 4095);
    check("lead_lock", lock, 0);

    // fb leads by 5: -40 per period, saturate at floor
    start(1'b1, 1'b1, 5, 0);
    run(15);
    check("lag_vctrl1", vctrl, 2008);
    run(1200);
    check("lag_floor", vctrl, 0);
    check("lag_lock", lock, 0);

    // d dropped mid-pulse, then restored
    start(1'b1, 1'b1, 0, 5);
    run(5);
    check("den_up_pre", up, 1);
    d = 1'b0;
    run(1);
    check("den_up", up, 0);
    check("den_vctrl", vctrl, 2056);
    check("den_lock", lock, 0);
    run(40);
    check("den_frozen", vctrl, 2056);
    d = 1'b1;
    run(200);
    check("den_resume_lock", lock, 0);

    // asynchronous reset mid-pulse
    start(1'b1, 1'b1, 0, 5);
    run(6);
    rst_n = 1'b0;
    #1;
    check("arst_up", up, 0);
    check("arst_vctrl", vctrl, 2048);
    @(posedge clk); #2;
    rst_n = 1'b1;
    run(40);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
